// File: rtl/seq_serializer.sv
// Parallel-to-serial converter, MSB first, with back-to-back streaming.
// Optional even-parity trailer cycle is enabled by defining SER_PARITY_EN.
module seq_serializer #(
    parameter int WIDTH = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ready,
    output logic             din,
    output logic             dout_valid,
    output logic             done
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT
`ifdef SER_PARITY_EN
        , PARITY
`endif
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] shreg_q;
    logic [CW-1:0]    cnt_q;
    logic             din_q;
    logic             dout_valid_q;
    logic             done_q;
    logic             load_ready_q;
`ifdef SER_PARITY_EN
    logic             par_q;
`endif

    assign load_ready = load_ready_q;
    assign din        = din_q;
    assign dout_valid = dout_valid_q;
    assign done       = done_q;

    // All outputs are registered and computed for the cycle that follows each edge;
    // shreg_q[WIDTH-1] always holds the bit currently on din during SHIFT.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            shreg_q      <= '0;
            cnt_q        <= '0;
            din_q        <= 1'b0;
            dout_valid_q <= 1'b0;
            done_q       <= 1'b0;
            load_ready_q <= 1'b1;
`ifdef SER_PARITY_EN
            par_q        <= 1'b0;
`endif
        end else if (load_valid && load_ready_q) begin
            state_q      <= SHIFT;
            shreg_q      <= load_data;
            cnt_q        <= CW'(WIDTH - 1);
            din_q        <= load_data[WIDTH-1];
            dout_valid_q <= 1'b1;
            done_q       <= 1'b0;
            load_ready_q <= 1'b0;
`ifdef SER_PARITY_EN
            par_q        <= ^load_data;
`endif
        end else begin
            case (state_q)
                SHIFT: begin
                    if (cnt_q != '0) begin
                        shreg_q      <= shreg_q << 1;
                        cnt_q        <= cnt_q - CW'(1);
                        din_q        <= shreg_q[WIDTH-2];
                        dout_valid_q <= 1'b1;
`ifdef SER_PARITY_EN
                        done_q       <= 1'b0;
                        load_ready_q <= 1'b0;
`else
                        done_q       <= (cnt_q == CW'(1));
                        load_ready_q <= (cnt_q == CW'(1));
`endif
                    end else begin
`ifdef SER_PARITY_EN
                        state_q      <= PARITY;
                        din_q        <= par_q;
                        dout_valid_q <= 1'b1;
                        done_q       <= 1'b1;
                        load_ready_q <= 1'b1;
`else
                        state_q      <= IDLE;
                        din_q        <= 1'b0;
                        dout_valid_q <= 1'b0;
                        done_q       <= 1'b0;
                        load_ready_q <= 1'b1;
`endif
                    end
                end
                default: begin
                    state_q      <= IDLE;
                    din_q        <= 1'b0;
                    dout_valid_q <= 1'b0;
                    done_q       <= 1'b0;
                    load_ready_q <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_serializer.sv
// Directed bench for seq_serializer: a 24-bit instance and a 2-bit instance.
// Parity expectations follow SER_PARITY_EN when the bench is built with it.
module tb_seq_serializer;

`ifdef SER_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int L24 = 24 + PAR;
    localparam int L2  = 2 + PAR;

    logic        clk = 1'b0;
    logic        rst, load_valid, load_ready, din, dout_valid, done;
    logic [23:0] load_data;
    logic        rst2, lv2, lr2, din2, dv2, done2;
    logic [1:0]  ld2;

    int n_chk = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    seq_serializer #(.WIDTH(24)) u_dut (
        .clk(clk), .rst(rst), .load_valid(load_valid), .load_data(load_data),
        .load_ready(load_ready), .din(din), .dout_valid(dout_valid), .done(done)
    );

    seq_serializer #(.WIDTH(2)) u_dut2 (
        .clk(clk), .rst(rst2), .load_valid(lv2), .load_data(ld2),
        .load_ready(lr2), .din(din2), .dout_valid(dv2), .done(done2)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " din"}, din, 1'b0);
        chk({tag, " dv"}, dout_valid, 1'b0);
        chk({tag, " done"}, done, 1'b0);
        chk({tag, " ready"}, load_ready, 1'b1);
    endtask

    // Called right after the accepting edge; checks cycles 1..L24 of word w.
    task automatic run_word(input logic [23:0] w, input bit chain, input logic [23:0] nw,
                            input bit noise);
        logic expd;
        for (int c = 1; c <= L24; c++) begin
            expd = (c <= 24) ? w[24-c] : ^w;
            chk($sformatf("din c%0d", c), din, expd);
            chk($sformatf("dv c%0d", c), dout_valid, 1'b1);
            chk($sformatf("done c%0d", c), done, (c == L24));
            chk($sformatf("ready c%0d", c), load_ready, (c == L24));
            if (c == L24) begin
                load_valid = chain;
                load_data  = chain ? nw : 24'h0;
            end else if (noise && c >= 2 && c <= 23) begin
                load_valid = 1'b1;
                load_data  = 24'h000000;
            end else begin
                load_valid = 1'b0;
            end
            tick();
        end
        load_valid = 1'b0;
        if (!chain) chk_idle("after word");
    endtask

    initial begin
        rst = 1'b1; load_valid = 1'b0; load_data = '0;
        rst2 = 1'b1; lv2 = 1'b0; ld2 = '0;
        tick(); tick();
        chk_idle("reset");
        chk("reset2 dv", dv2, 1'b0);
        chk("reset2 ready", lr2, 1'b1);
        rst = 1'b0; rst2 = 1'b0;
        tick();
        chk_idle("post reset");

        // single word, then back-to-back 555D55 -> FFFFFF
        load_valid = 1'b1; load_data = 24'h555D55;
        tick();
        run_word(24'h555D55, 1'b1, 24'hFFFFFF, 1'b0);
        run_word(24'hFFFFFF, 1'b0, 24'h0, 1'b0);

        // ignored offers while busy; the chained word is the only acceptance
        load_valid = 1'b1; load_data = 24'h555D55;
        tick();
        run_word(24'h555D55, 1'b1, 24'hA5C381, 1'b1);
        run_word(24'hA5C381, 1'b0, 24'h0, 1'b0);

        // reset mid-word at cycle 10
        load_valid = 1'b1; load_data = 24'h555D55;
        tick();
        load_valid = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            chk($sformatf("pre-rst din c%0d", c), din, (24'h555D55 >> (24 - c)) & 1);
            tick();
        end
        chk("rst c10 dv", dout_valid, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_idle("rst c11");
        for (int c = 12; c <= 40; c++) begin
            tick();
            chk($sformatf("aborted dv c%0d", c), dout_valid, 1'b0);
        end

        // WIDTH=2: accept 2'b10
        lv2 = 1'b1; ld2 = 2'b10;
        tick();
        lv2 = 1'b0;
        chk("w2 c1 din", din2, 1'b1);
        chk("w2 c1 done", done2, 1'b0);
        chk("w2 c1 ready", lr2, (L2 == 1));
        tick();
        chk("w2 c2 din", din2, 1'b0);
        chk("w2 c2 done", done2, (L2 == 2));
        chk("w2 c2 ready", lr2, (L2 == 2));
        if (PAR != 0) begin
            tick();
            chk("w2 c3 par", din2, 1'b1);
            chk("w2 c3 done", done2, 1'b1);
        end
        tick();
        chk("w2 idle dv", dv2, 1'b0);
        chk("w2 idle ready", lr2, 1'b1);

        // reset beats a simultaneous offer
        rst2 = 1'b1; lv2 = 1'b1; ld2 = 2'b11;
        tick();
        rst2 = 1'b0; lv2 = 1'b0;
        chk("w2 rst+load dv", dv2, 1'b0);
        chk("w2 rst+load din", din2, 1'b0);
        chk("w2 rst+load ready", lr2, 1'b1);
        tick();
        chk("w2 discarded dv", dv2, 1'b0);
        chk("w2 discarded done", done2, 1'b0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
